// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vip_pkg
// Description : Shared definitions for the Avalon-ST Video frame reader:
//               packet-type identifiers, reader state encoding and the
//               RGB565 -> RGB888 expansion helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

  // Avalon-ST Video packet identifiers carried in the low nibble of the
  // header beat.
  localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;
  localparam logic [3:0] VIP_PKT_CTRL  = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_CHDR = 4'd2,
    ST_CTL0 = 4'd3,
    ST_CTL1 = 4'd4,
    ST_CTL2 = 4'd5,
    ST_VHDR = 4'd6,
    ST_PIX  = 4'd7,
    ST_DONE = 4'd8
  } fsr_state_t;

  // Replicate the MSBs into the new LSBs so full-scale stays full-scale.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/st_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : st_skid_buf
// Description : Two-entry valid/ready buffer. Output side is fully
//               registered; the producer is expected to respect the
//               occupancy output (a push into a full, non-draining buffer
//               is dropped).
// Ports       : clk, reset_n      - clock, async active-low reset
//               in_valid/in_data  - write side
//               out_valid/out_data/out_ready - read side (ready latency 0)
//               occupancy         - number of entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module st_skid_buf #(
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    occupancy
);

  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [1:0]    r_occ;
  logic          w_push;
  logic          w_pop;

  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_head;
  assign occupancy = r_occ;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = in_valid && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (w_push) begin
            r_head <= in_data;
            r_occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= in_data;
          end else if (w_push) begin
            r_tail <= in_data;
            r_occ  <= 2'd2;
          end else if (w_pop) begin
            r_occ  <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) r_tail <= in_data;
            else        r_occ  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_stream_reader
// Description : Reads one RGB565 frame from the SDRAM read-FIFO and emits it
//               as an Avalon-ST Video control packet followed by a video
//               packet of RGB888 pixels.
// Ports       : clk, reset_n                 - clock, async active-low reset
//               frame_start                  - one-cycle start pulse
//               rd_req/rd_data/rd_empty      - read-FIFO pop interface
//               rd_load/rd_start_addr/rd_max_addr/rd_len - read-side setup
//               st_data/st_valid/st_sop/st_eop/st_ready - Avalon-ST source
//               busy, frame_done             - status
// Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_reader
  import vip_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int ASIZE      = 23,
  parameter int FRAME_BASE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  output logic             rd_req,
  input  logic [15:0]      rd_data,
  input  logic             rd_empty,
  output logic             rd_load,
  output logic [ASIZE-1:0] rd_start_addr,
  output logic [ASIZE-1:0] rd_max_addr,
  output logic [10:0]      rd_len,
  output logic [23:0]      st_data,
  output logic             st_valid,
  output logic             st_sop,
  output logic             st_eop,
  input  logic             st_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam int                c_TOTAL   = WIDTH * HEIGHT;
  localparam int                c_RCW     = $clog2(c_TOTAL + 1);
  localparam logic [c_RCW-1:0]  c_TOTAL_R = c_RCW'(c_TOTAL);
  localparam logic [11:0]       c_XLAST   = 12'(WIDTH - 1);
  localparam logic [11:0]       c_YLAST   = 12'(HEIGHT - 1);
  localparam logic [15:0]       c_W       = 16'(WIDTH);
  localparam logic [15:0]       c_H       = 16'(HEIGHT);

  // Control-packet beats: three 4-bit symbols per beat at [3:0],[11:8],[19:16].
  localparam logic [23:0] c_BEAT_CHDR = {20'h0, VIP_PKT_CTRL};
  localparam logic [23:0] c_BEAT_CTL0 = {4'h0, c_W[7:4],  4'h0, c_W[11:8],  4'h0, c_W[15:12]};
  localparam logic [23:0] c_BEAT_CTL1 = {4'h0, c_H[11:8], 4'h0, c_H[15:12], 4'h0, c_W[3:0]};
  localparam logic [23:0] c_BEAT_CTL2 = {4'h0, 4'h0,      4'h0, c_H[3:0],   4'h0, c_H[7:4]};
  localparam logic [23:0] c_BEAT_VHDR = {20'h0, VIP_PKT_VIDEO};

  fsr_state_t       r_state;
  logic             r_hdr_valid;
  logic             r_hdr_sop;
  logic             r_hdr_eop;
  logic [23:0]      r_hdr_data;
  logic             r_rd_load;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_inflight;
  logic [c_RCW-1:0] r_req_cnt;
  logic [11:0]      r_x;
  logic [11:0]      r_y;

  logic             w_buf_valid;
  logic [24:0]      w_buf_data;
  logic [1:0]       w_occ;
  logic             w_pix_xfer;
  logic             w_hdr_xfer;
  logic             w_rd_req;
  logic [2:0]       w_slots_used;
  logic             w_last_pix;

  assign w_pix_xfer = w_buf_valid && st_ready;
  assign w_hdr_xfer = r_hdr_valid && st_ready;
  assign w_last_pix = (r_x == c_XLAST) && (r_y == c_YLAST);

  // Space accounting counts the beat leaving this cycle as already gone so
  // the pipeline sustains one pixel per clock. A transfer implies occ >= 1,
  // so the subtraction cannot wrap.
  assign w_slots_used = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pix_xfer};
  assign w_rd_req     = (r_state == ST_PIX) && !rd_empty &&
                        (w_slots_used < 3'd2) && (r_req_cnt < c_TOTAL_R);

  st_skid_buf #(
    .DW (25)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (r_inflight),
    .in_data   ({w_last_pix, rgb565_to_888(rd_data)}),
    .out_valid (w_buf_valid),
    .out_data  (w_buf_data),
    .out_ready (st_ready),
    .occupancy (w_occ)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_hdr_valid  <= 1'b0;
      r_hdr_sop    <= 1'b0;
      r_hdr_eop    <= 1'b0;
      r_hdr_data   <= '0;
      r_rd_load    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_inflight   <= 1'b0;
      r_req_cnt    <= '0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_rd_load    <= 1'b0;
      r_frame_done <= 1'b0;
      r_inflight   <= w_rd_req;
      if (w_rd_req) r_req_cnt <= r_req_cnt + 1'b1;

      // Raster position tracks the word entering the buffer.
      if (r_inflight) begin
        if (r_x == c_XLAST) begin
          r_x <= '0;
          r_y <= r_y + 12'd1;
        end else begin
          r_x <= r_x + 12'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state   <= ST_LOAD;
            r_busy    <= 1'b1;
            r_rd_load <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state     <= ST_CHDR;
          r_hdr_valid <= 1'b1;
          r_hdr_sop   <= 1'b1;
          r_hdr_eop   <= 1'b0;
          r_hdr_data  <= c_BEAT_CHDR;
          r_req_cnt   <= '0;
          r_x         <= '0;
          r_y         <= '0;
        end
        ST_CHDR: begin
          if (w_hdr_xfer) begin
            r_state    <= ST_CTL0;
            r_hdr_sop  <= 1'b0;
            r_hdr_data <= c_BEAT_CTL0;
          end
        end
        ST_CTL0: begin
          if (w_hdr_xfer) begin
            r_state    <= ST_CTL1;
            r_hdr_data <= c_BEAT_CTL1;
          end
        end
        ST_CTL1: begin
          if (w_hdr_xfer) begin
            r_state    <= ST_CTL2;
            r_hdr_eop  <= 1'b1;
            r_hdr_data <= c_BEAT_CTL2;
          end
        end
        ST_CTL2: begin
          if (w_hdr_xfer) begin
            r_state    <= ST_VHDR;
            r_hdr_sop  <= 1'b1;
            r_hdr_eop  <= 1'b0;
            r_hdr_data <= c_BEAT_VHDR;
          end
        end
        ST_VHDR: begin
          if (w_hdr_xfer) begin
            r_state     <= ST_PIX;
            r_hdr_valid <= 1'b0;
            r_hdr_sop   <= 1'b0;
          end
        end
        ST_PIX: begin
          if (w_pix_xfer && w_buf_data[24]) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Header beats own the bus outside PIX; the pixel buffer only holds data
  // inside PIX, so the two sources never overlap.
  assign st_valid   = r_hdr_valid | w_buf_valid;
  assign st_data    = r_hdr_valid ? r_hdr_data : w_buf_data[23:0];
  assign st_sop     = r_hdr_valid & r_hdr_sop;
  assign st_eop     = r_hdr_valid ? r_hdr_eop : (w_buf_valid & w_buf_data[24]);

  assign rd_req        = w_rd_req;
  assign rd_load       = r_rd_load;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign rd_start_addr = ASIZE'(FRAME_BASE);
  assign rd_max_addr   = ASIZE'(FRAME_BASE + c_TOTAL);
  assign rd_len        = 11'd256;

endmodule
`default_nettype wire
